// File: rtl/ifetch_stage.sv
// ifetch_stage: MIPS instruction-fetch stage with PC, IF/ID register, stall/flush/redirect and misalignment trap.
// Ports: clk, rst_n (async active-low); imem_addr/imem_rdata to instruction memory;
// stall_i, flush_i, redirect_valid_i, redirect_pc_i from hazard unit / EX;
// if_id_valid, if_id_instr, if_id_pc, if_id_pc4 to decode; misalign_o fault flag; pc_o debug PC.
// Optional macro IFETCH_PERF_CNT_EN adds perf_fetch_cnt and perf_stall_cnt counters.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        misalign_o,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [31:0] pc_o
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d, pc_plus4;
  logic valid_q, valid_d, redir_ok, redir_bad, load_en;
  assign pc_plus4  = pc_q + 32'd4;
  assign redir_ok  = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);
  assign redir_bad = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  // A real instruction enters IF/ID only in RUN with no flush, redirect or stall.
  assign load_en   = (state_q == RUN) && !flush_i && !redirect_valid_i && !stall_i;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    case (state_q)
      RUN: begin
        if (redir_ok) pc_d = redirect_pc_i;
        else if (redir_bad) state_d = FAULT;
        else if (!stall_i) pc_d = pc_plus4;
        if (flush_i || redirect_valid_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (!stall_i) begin
          valid_d  = 1'b1;
          instr_d  = imem_rdata;
          id_pc_d  = pc_q;
          id_pc4_d = pc_plus4;
        end
      end
      // PC frozen and IF/ID kept empty until an aligned target arrives.
      FAULT: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        if (redir_ok) begin
          pc_d    = redirect_pc_i;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      id_pc_q  <= 32'h0;
      id_pc4_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    fetch_cnt_d = load_en ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    stall_cnt_d = (state_q == RUN && stall_i) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif
  assign imem_addr   = pc_q;
  assign pc_o        = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_pc4   = id_pc4_q;
  assign misalign_o  = (state_q == FAULT);
endmodule
